mod_cfg_sequencer: RTL and testbench
====================================

Name: mod_cfg_sequencer

Overview:
Configuration controller in front of the FOG square-wave modulation generator. Accepts new period and amplitude settings from the host register bank through a valid/ready handshake. Applies the period only at a modulation half-period boundary, marked by the generator's step-trigger pulse. Slews both amplitudes toward their targets in bounded steps, one step per boundary, so the modulation output never jumps by more than AMP_STEP. Sits between the host register interface and the generator's i_freq_cnt, i_amp_H and i_amp_L inputs.

Parameters:
OUTPUT_BIT, 32, width of the signed amplitude values
AMP_STEP, 64, maximum amplitude change per boundary (positive)
MIN_FREQ_CNT, 2, smallest legal half-period count; smaller requests are rejected
DEFAULT_FREQ_CNT, 100, o_freq_cnt value after reset
TIMEOUT_CYC, 1000000, watchdog limit in clocks (used only with the optional feature)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_cfg_valid  in  1  host offers a new configuration
o_cfg_ready  out  1  block can accept a configuration (high only in IDLE)
i_cfg_freq_cnt  in  32  requested half-period count
i_cfg_amp_H  in  OUTPUT_BIT  requested high amplitude (signed)
i_cfg_amp_L  in  OUTPUT_BIT  requested low amplitude (signed)
i_stepTrig  in  1  one-clock pulse from the generator at each half-period boundary
o_freq_cnt  out  32  to generator i_freq_cnt
o_amp_H  out  OUTPUT_BIT  to generator i_amp_H (signed)
o_amp_L  out  OUTPUT_BIT  to generator i_amp_L (signed)
o_busy  out  1  a configuration is pending or slewing
o_commit  out  1  one-clock pulse when all outputs equal the accepted targets
o_cfg_err  out  1  one-clock pulse when a request is rejected

Behaviour:
- Reset values: o_freq_cnt=DEFAULT_FREQ_CNT, o_amp_H=0, o_amp_L=0, o_cfg_ready=1, o_busy=0, o_commit=0, o_cfg_err=0, state=IDLE, shadow registers=0.
- All outputs are registered.
- States: IDLE, PEND, SLEW.
- IDLE:
  - o_cfg_ready=1.
  - A transfer occurs on valid&ready.
  - If i_cfg_freq_cnt < MIN_FREQ_CNT: pulse o_cfg_err on the next cycle, stay in IDLE, leave shadows and outputs unchanged.
  - Otherwise: latch all three fields into shadow registers and go to PEND on the next cycle.
- PEND:
  - o_busy=1, o_cfg_ready=0.
  - On i_stepTrig: o_freq_cnt<=shadow_freq, then go to SLEW.
  - If the amplitude targets already equal the outputs, go instead to IDLE and pulse o_commit on that same transition.
- SLEW:
  - On each i_stepTrig, o_amp_H and o_amp_L each move toward their target independently.
  - Compute diff = target - current in OUTPUT_BIT+1 signed bits (no overflow).
  - If |diff| <= AMP_STEP: current <= target. Otherwise current <= current ± AMP_STEP, with the sign of diff.
  - When both amplitudes equal their targets after an update: go to IDLE and pulse o_commit (same cycle as that final update plus one register stage).
- o_busy = (state != IDLE).
- i_cfg_valid outside IDLE is ignored; the host holds valid until ready.
- A new request in the same cycle as o_commit is not accepted; it is accepted on the following cycle (ready rises when IDLE is re-entered).
- i_stepTrig in IDLE has no effect.
- Asynchronous reset mid-PEND or mid-SLEW returns all outputs to their reset values immediately; the partially applied configuration is discarded.
- Latency: o_freq_cnt changes 1 clock after the first i_stepTrig following acceptance. The worst-case slew length is ceil(max|diff|/AMP_STEP) boundaries.

Optional Feature:
- Macro MOD_CFG_WATCHDOG_EN.
- When defined:
  - A counter clears on entering PEND and on every i_stepTrig, and increments every clock while in PEND or SLEW.
  - On reaching TIMEOUT_CYC: load all shadow values directly into the outputs, go to IDLE, and pulse both o_commit and o_cfg_err on the same cycle.
  - This covers a stalled generator.
- When undefined: no counter; PEND and SLEW wait indefinitely for i_stepTrig.

Decomposition:
- Shared package fog_mod_pkg:
  - state encoding typedef (IDLE/PEND/SLEW)
  - DEFAULT_FREQ_CNT and MIN_FREQ_CNT constants
  - the amplitude width constant, shared with the modulation generator
- One sub-module: mod_amp_slew. It is a single-channel signed step limiter (inputs: current, target, step enable; outputs: next value, at_target) and is instantiated twice, for H and L.

Test Plan:
- Reset, then no stimulus -> o_freq_cnt=100, amps=0, o_cfg_ready=1, no pulses.
- Request freq=50, H=100, L=-100 with AMP_STEP=64; trigger stepTrig every 51 clocks:
  - freq becomes 50 at the first trigger
  - H goes 64 then 100; L goes -64 then -100
  - o_commit pulses after the second slew trigger.
- Request freq=1 -> o_cfg_err pulse; outputs and state unchanged; o_cfg_ready stays 1.
- From H=0x7FFFFFF0, request H=-0x7FFFFFF0 -> each step is exactly -64 with no overflow wrap, and the final value is exact.
- Second valid asserted during SLEW -> not accepted until after o_commit; then accepted and processed normally.
- Assert reset mid-SLEW (H=64 of target 100) -> all outputs return to reset values asynchronously.
- With MOD_CFG_WATCHDOG_EN and TIMEOUT_CYC=20, no stepTrig -> 20 clocks after PEND entry, outputs equal the targets and o_commit and o_cfg_err pulse together.

Source files
------------

// File: rtl/fog_mod_pkg.sv
// -----------------------------------------------------------------------------
// fog_mod_pkg
// Shared definitions for the FOG modulation path: the configuration
// sequencer state encoding and the constants it shares with the square-wave
// modulation generator.
//   AMP_W                 : signed amplitude width used by the generator
//   FOG_DEFAULT_FREQ_CNT  : half-period count driven after reset
//   FOG_MIN_FREQ_CNT      : smallest half-period count the generator accepts
// -----------------------------------------------------------------------------
package fog_mod_pkg;

    localparam int          AMP_W                = 32;
    localparam int unsigned FOG_DEFAULT_FREQ_CNT = 100;
    localparam int unsigned FOG_MIN_FREQ_CNT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SLEW = 2'd2
    } seq_state_t;

endpackage

// File: rtl/mod_amp_slew.sv
// -----------------------------------------------------------------------------
// mod_amp_slew
// Single-channel signed step limiter. Combinational: given the current
// amplitude and its target, produces the value after one boundary step.
// Ports:
//   i_cur       : current amplitude (signed, W bits)
//   i_target    : target amplitude (signed, W bits)
//   i_en        : take a step this cycle; when low o_next = i_cur
//   o_next      : amplitude after the (optional) step
//   o_at_target : o_next equals i_target
// -----------------------------------------------------------------------------
module mod_amp_slew #(
    parameter int W    = 32,
    parameter int STEP = 64
) (
    input  logic signed [W-1:0] i_cur,
    input  logic signed [W-1:0] i_target,
    input  logic                i_en,
    output logic signed [W-1:0] o_next,
    output logic                o_at_target
);

    localparam logic signed [W:0] STEP_P = (W+1)'(STEP);

    // One extra bit so full-scale swings (e.g. max to min) cannot wrap.
    logic signed [W:0] w_diff;

    assign w_diff = $signed({i_target[W-1], i_target}) - $signed({i_cur[W-1], i_cur});

    // When the remaining distance exceeds STEP the intermediate value lies
    // strictly between current and target, so the W-bit add cannot overflow.
    always_comb begin
        o_next = i_cur;
        if (i_en) begin
            if (w_diff > STEP_P) begin
                o_next = i_cur + W'(STEP);
            end else if (w_diff < -STEP_P) begin
                o_next = i_cur - W'(STEP);
            end else begin
                o_next = i_target;
            end
        end
    end

    assign o_at_target = (o_next == i_target);

endmodule

// File: rtl/mod_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// mod_cfg_sequencer
// Configuration controller in front of the FOG square-wave modulation
// generator. A host request (period + two amplitudes) is taken over a
// valid/ready handshake, the period is applied at the next half-period
// boundary (i_stepTrig), then both amplitudes slew toward their targets by at
// most AMP_STEP per boundary.
//
// Handshake: a request transfers on a rising clock edge where i_cfg_valid and
// o_cfg_ready are both high. o_cfg_ready is high only in IDLE and stays low in
// the o_commit cycle. The host holds valid and fields stable until transfer.
//
// Ports:
//   i_clk, i_rst_n           : clock, asynchronous active-low reset
//   i_cfg_valid/o_cfg_ready  : request handshake
//   i_cfg_freq_cnt           : requested half-period count (< MIN rejected)
//   i_cfg_amp_H/i_cfg_amp_L  : requested signed amplitudes
//   i_stepTrig               : generator half-period boundary pulse
//   o_freq_cnt, o_amp_H/L    : registered values to the generator
//   o_busy                   : request pending or slewing
//   o_commit                 : pulse when outputs reached accepted targets
//   o_cfg_err                : pulse when a request is rejected
//   o_state                  : current FSM state, for debug
//
// Optional feature: define MOD_CFG_WATCHDOG_EN to force-apply the pending
// configuration if no boundary arrives within TIMEOUT_CYC clocks; that event
// pulses o_commit and o_cfg_err together.
// -----------------------------------------------------------------------------
module mod_cfg_sequencer
    import fog_mod_pkg::*;
#(
    parameter int          OUTPUT_BIT       = fog_mod_pkg::AMP_W,
    parameter int          AMP_STEP         = 64,
    parameter int unsigned MIN_FREQ_CNT     = fog_mod_pkg::FOG_MIN_FREQ_CNT,
    parameter int unsigned DEFAULT_FREQ_CNT = fog_mod_pkg::FOG_DEFAULT_FREQ_CNT,
    parameter int unsigned TIMEOUT_CYC      = 1000000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_cfg_valid,
    output logic                         o_cfg_ready,
    input  logic [31:0]                  i_cfg_freq_cnt,
    input  logic signed [OUTPUT_BIT-1:0] i_cfg_amp_H,
    input  logic signed [OUTPUT_BIT-1:0] i_cfg_amp_L,
    input  logic                         i_stepTrig,
    output logic [31:0]                  o_freq_cnt,
    output logic signed [OUTPUT_BIT-1:0] o_amp_H,
    output logic signed [OUTPUT_BIT-1:0] o_amp_L,
    output logic                         o_busy,
    output logic                         o_commit,
    output logic                         o_cfg_err,
    output seq_state_t                   o_state
);

    seq_state_t                   r_state, w_state_nx;
    logic [31:0]                  r_freq_cnt, w_freq_nx;
    logic signed [OUTPUT_BIT-1:0] r_amp_H, w_amp_H_nx;
    logic signed [OUTPUT_BIT-1:0] r_amp_L, w_amp_L_nx;
    logic [31:0]                  r_shd_freq, w_shd_freq_nx;
    logic signed [OUTPUT_BIT-1:0] r_shd_amp_H, w_shd_amp_H_nx;
    logic signed [OUTPUT_BIT-1:0] r_shd_amp_L, w_shd_amp_L_nx;
    logic                         r_cfg_ready, w_ready_nx;
    logic                         r_busy, w_busy_nx;
    logic                         r_commit, w_commit_nx;
    logic                         r_cfg_err, w_err_nx;

    logic                         w_slew_en;
    logic signed [OUTPUT_BIT-1:0] w_next_H, w_next_L;
    logic                         w_at_H, w_at_L;

    // Steps only happen on boundaries while slewing; in PEND the limiters
    // are disabled so at_target reports whether no slew is needed at all.
    assign w_slew_en = (r_state == ST_SLEW) && i_stepTrig;

    mod_amp_slew #(.W(OUTPUT_BIT), .STEP(AMP_STEP)) u_slew_h (
        .i_cur       (r_amp_H),
        .i_target    (r_shd_amp_H),
        .i_en        (w_slew_en),
        .o_next      (w_next_H),
        .o_at_target (w_at_H)
    );

    mod_amp_slew #(.W(OUTPUT_BIT), .STEP(AMP_STEP)) u_slew_l (
        .i_cur       (r_amp_L),
        .i_target    (r_shd_amp_L),
        .i_en        (w_slew_en),
        .o_next      (w_next_L),
        .o_at_target (w_at_L)
    );

`ifdef MOD_CFG_WATCHDOG_EN
    logic [31:0] r_wd_cnt, w_wd_cnt_nx;
    logic        w_wd_expire;

    // Held at zero in IDLE, so it starts from zero on PEND entry.
    always_comb begin
        w_wd_expire = (r_state != ST_IDLE) && !i_stepTrig &&
                      (r_wd_cnt == 32'(TIMEOUT_CYC - 32'd1));
        if ((r_state == ST_IDLE) || i_stepTrig) begin
            w_wd_cnt_nx = '0;
        end else begin
            w_wd_cnt_nx = r_wd_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= w_wd_cnt_nx;
        end
    end
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_freq_nx      = r_freq_cnt;
        w_amp_H_nx     = r_amp_H;
        w_amp_L_nx     = r_amp_L;
        w_shd_freq_nx  = r_shd_freq;
        w_shd_amp_H_nx = r_shd_amp_H;
        w_shd_amp_L_nx = r_shd_amp_L;
        w_commit_nx    = 1'b0;
        w_err_nx       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_cfg_valid && r_cfg_ready) begin
                    if (i_cfg_freq_cnt < 32'(MIN_FREQ_CNT)) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_shd_freq_nx  = i_cfg_freq_cnt;
                        w_shd_amp_H_nx = i_cfg_amp_H;
                        w_shd_amp_L_nx = i_cfg_amp_L;
                        w_state_nx     = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (i_stepTrig) begin
                    w_freq_nx = r_shd_freq;
                    if (w_at_H && w_at_L) begin
                        w_state_nx  = ST_IDLE;
                        w_commit_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_SLEW;
                    end
                end
            end
            ST_SLEW: begin
                if (i_stepTrig) begin
                    w_amp_H_nx = w_next_H;
                    w_amp_L_nx = w_next_L;
                    if (w_at_H && w_at_L) begin
                        w_state_nx  = ST_IDLE;
                        w_commit_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

`ifdef MOD_CFG_WATCHDOG_EN
        if (w_wd_expire) begin
            w_freq_nx   = r_shd_freq;
            w_amp_H_nx  = r_shd_amp_H;
            w_amp_L_nx  = r_shd_amp_L;
            w_state_nx  = ST_IDLE;
            w_commit_nx = 1'b1;
            w_err_nx    = 1'b1;
        end
`endif

        // Ready is withheld during the commit cycle so a held request is
        // taken only once IDLE has been re-entered.
        w_ready_nx = (w_state_nx == ST_IDLE) && !w_commit_nx;
        w_busy_nx  = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_freq_cnt  <= 32'(DEFAULT_FREQ_CNT);
            r_amp_H     <= '0;
            r_amp_L     <= '0;
            r_shd_freq  <= '0;
            r_shd_amp_H <= '0;
            r_shd_amp_L <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_commit    <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_freq_cnt  <= w_freq_nx;
            r_amp_H     <= w_amp_H_nx;
            r_amp_L     <= w_amp_L_nx;
            r_shd_freq  <= w_shd_freq_nx;
            r_shd_amp_H <= w_shd_amp_H_nx;
            r_shd_amp_L <= w_shd_amp_L_nx;
            r_cfg_ready <= w_ready_nx;
            r_busy      <= w_busy_nx;
            r_commit    <= w_commit_nx;
            r_cfg_err   <= w_err_nx;
        end
    end

    assign o_state     = r_state;
    assign o_freq_cnt  = r_freq_cnt;
    assign o_amp_H     = r_amp_H;
    assign o_amp_L     = r_amp_L;
    assign o_cfg_ready = r_cfg_ready;
    assign o_busy      = r_busy;
    assign o_commit    = r_commit;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_mod_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mod_cfg_sequencer
// Self-checking bench for mod_cfg_sequencer (AMP_STEP=64, TIMEOUT_CYC=20).
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge. Expected output triples are queued when a boundary pulse is
// driven and compared after the DUT has registered it.
// -----------------------------------------------------------------------------
module tb_mod_cfg_sequencer;
    import fog_mod_pkg::*;

    localparam int STEP = 64;

    logic               clk;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [31:0]        cfg_freq;
    logic signed [31:0] cfg_h;
    logic signed [31:0] cfg_l;
    logic               step_trig;
    logic [31:0]        freq_cnt;
    logic signed [31:0] amp_h;
    logic signed [31:0] amp_l;
    logic               busy;
    logic               commit;
    logic               cfg_err;
    seq_state_t         dbg_state;

    logic signed [31:0] sl_cur, sl_tgt, sl_next;
    logic               sl_en, sl_at;

    int n_checks = 0;
    int n_errors = 0;

    logic [95:0] exp_q[$];

    // reference model of the committed outputs and pending targets
    longint m_freq, m_h, m_l, m_tf, m_th, m_tl;
    bit     m_pend;

    mod_cfg_sequencer #(.AMP_STEP(STEP), .TIMEOUT_CYC(20)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cfg_valid    (cfg_valid),
        .o_cfg_ready    (cfg_ready),
        .i_cfg_freq_cnt (cfg_freq),
        .i_cfg_amp_H    (cfg_h),
        .i_cfg_amp_L    (cfg_l),
        .i_stepTrig     (step_trig),
        .o_freq_cnt     (freq_cnt),
        .o_amp_H        (amp_h),
        .o_amp_L        (amp_l),
        .o_busy         (busy),
        .o_commit       (commit),
        .o_cfg_err      (cfg_err),
        .o_state        (dbg_state)
    );

    mod_amp_slew #(.W(32), .STEP(STEP)) u_slew_chk (
        .i_cur       (sl_cur),
        .i_target    (sl_tgt),
        .i_en        (sl_en),
        .o_next      (sl_next),
        .o_at_target (sl_at)
    );

    // ---------------- clock / global time limit ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint step_model(input longint cur, input longint tgt);
        longint d;
        d = tgt - cur;
        if (d > STEP)       return cur + STEP;
        else if (d < -STEP) return cur - STEP;
        else                return tgt;
    endfunction

    function automatic logic [95:0] pack3(input longint f, input longint h, input longint l);
        logic [31:0] f32, h32, l32;
        f32 = 32'(f);
        h32 = 32'(h);
        l32 = 32'(l);
        return {f32, h32, l32};
    endfunction

    task automatic model_reset();
        m_freq = 100; m_h = 0; m_l = 0;
        m_tf = 0; m_th = 0; m_tl = 0;
        m_pend = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; step_trig = 1'b0;
        cfg_freq = '0; cfg_h = '0; cfg_l = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_outputs"}, {freq_cnt, amp_h, amp_l}, pack3(m_freq, m_h, m_l));
        chk({tag, "_ready"},   96'(cfg_ready), 96'(1));
        chk({tag, "_busy"},    96'(busy),      96'(0));
        chk({tag, "_state"},   96'(dbg_state), 96'(ST_IDLE));
    endtask

    // Offer a request and hold it until it transfers; then check the
    // immediate response (error pulse or entry into PEND).
    task automatic send_cfg(input logic [31:0] f, input longint h, input longint l);
        bit rdy;
        bit done;
        done = 1'b0;
        @(posedge clk);
        #1;
        cfg_valid = 1'b1; cfg_freq = f; cfg_h = 32'(h); cfg_l = 32'(l);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = cfg_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        #1 cfg_valid = 1'b0;
        chk("cfg_transfer", 96'(done), 96'(1));
        @(negedge clk);
        if (f < 32'd2) begin
            chk("err_pulse", 96'(cfg_err), 96'(1));
            chk("err_commit", 96'(commit), 96'(0));
            check_idle("err");
            @(negedge clk);
            chk("err_clear", 96'(cfg_err), 96'(0));
            check_idle("err_after");
        end else begin
            m_tf = f; m_th = h; m_tl = l; m_pend = 1'b1;
            chk("acc_busy",  96'(busy),      96'(1));
            chk("acc_ready", 96'(cfg_ready), 96'(0));
            chk("acc_err",   96'(cfg_err),   96'(0));
            chk("acc_hold",  {freq_cnt, amp_h, amp_l}, pack3(m_freq, m_h, m_l));
        end
    endtask

    // One boundary pulse; the model result is queued when it is driven.
    task automatic trigger_once(output bit committed);
        bit ec;
        logic [95:0] e;
        if (m_pend) begin
            m_freq = m_tf;
            if (m_h == m_th && m_l == m_tl) ec = 1'b1;
            else begin ec = 1'b0; m_pend = 1'b0; end
        end else begin
            m_h = step_model(m_h, m_th);
            m_l = step_model(m_l, m_tl);
            ec = (m_h == m_th) && (m_l == m_tl);
        end
        exp_q.push_back(pack3(m_freq, m_h, m_l));
        @(posedge clk);
        #1 step_trig = 1'b1;
        @(posedge clk);
        #1 step_trig = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("trig_outputs", {freq_cnt, amp_h, amp_l}, e);
        chk("trig_commit",  96'(commit),    96'(ec));
        chk("trig_busy",    96'(busy),      96'(!ec));
        chk("trig_ready",   96'(cfg_ready), 96'(0));
        chk("trig_err",     96'(cfg_err),   96'(0));
        committed = ec;
    endtask

    task automatic run_slew(input int exp_trigs);
        int n;
        bit c;
        n = 0; c = 1'b0;
        while (!c && n < 40) begin
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                chk("gap_commit", 96'(commit), 96'(0));
            end
            trigger_once(c);
            n++;
        end
        chk("trig_count", 96'(n), 96'(exp_trigs));
        @(negedge clk);
        chk("post_commit_pulse", 96'(commit), 96'(0));
        check_idle("post_commit");
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic signed [31:0] cur;
        logic signed [31:0] tgt;
        logic               en;
        logic signed [31:0] exp_next;
        logic               exp_at;
    } slew_vec_t;

    typedef struct {
        logic [31:0] freq;
        longint      h;
        longint      l;
        int          exp_trigs; // 0 = rejected request
    } cfg_vec_t;

    slew_vec_t sv[11];
    cfg_vec_t  cv[7];

    initial begin
        bit c;
        int wd_n;

        sv[0]  = '{32'sh7FFFFFF0, -32'sh7FFFFFF0, 1'b1, 32'sh7FFFFFB0, 1'b0};
        sv[1]  = '{-32'sh7FFFFFF0, 32'sh7FFFFFF0, 1'b1, -32'sh7FFFFFB0, 1'b0};
        sv[2]  = '{32'sh7FFFFFFF, 32'sh80000000, 1'b1, 32'sh7FFFFFBF, 1'b0};
        sv[3]  = '{32'sh80000000, 32'sh7FFFFFFF, 1'b1, 32'sh80000040, 1'b0};
        sv[4]  = '{32'sd0, 32'sd64, 1'b1, 32'sd64, 1'b1};
        sv[5]  = '{32'sd0, 32'sd65, 1'b1, 32'sd64, 1'b0};
        sv[6]  = '{32'sd0, -32'sd64, 1'b1, -32'sd64, 1'b1};
        sv[7]  = '{32'sd10, -32'sd55, 1'b1, -32'sd54, 1'b0};
        sv[8]  = '{32'sd5, 32'sd100, 1'b0, 32'sd5, 1'b0};
        sv[9]  = '{32'sd7, 32'sd7, 1'b0, 32'sd7, 1'b1};
        sv[10] = '{-32'sh7FFFFFC8, -32'sh7FFFFFF0, 1'b1, -32'sh7FFFFFF0, 1'b1};

        cv[0] = '{32'd50,         100, -100, 3};
        cv[1] = '{32'd1,          5,   5,    0};
        cv[2] = '{32'd0,          7,   7,    0};
        cv[3] = '{32'd2,          100, -100, 1};
        cv[4] = '{32'd77,         36,  -36,  2};
        cv[5] = '{32'hFFFF_FFFF,  200, -300, 6};
        cv[6] = '{32'd9,          200, 0,    6};

        sl_cur = '0; sl_tgt = '0; sl_en = 1'b0;
        do_reset();

        // step limiter in isolation, including full-scale swings
        for (int i = 0; i < 11; i++) begin
            sl_cur = sv[i].cur; sl_tgt = sv[i].tgt; sl_en = sv[i].en;
            #1;
            chk($sformatf("slew_next[%0d]", i), 96'(sl_next), 96'(sv[i].exp_next));
            chk($sformatf("slew_at[%0d]", i),   96'(sl_at),   96'(sv[i].exp_at));
        end

        // reset state, and boundary pulses in IDLE change nothing
        @(negedge clk);
        check_idle("reset");
        chk("reset_pulses", {94'(0), commit, cfg_err}, 96'(0));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 step_trig = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_idle("idle_trig");
            chk("idle_trig_commit", 96'(commit), 96'(0));
        end
        @(posedge clk);
        #1 step_trig = 1'b0;

        // table of requests applied back to back
        for (int i = 0; i < 7; i++) begin
            send_cfg(cv[i].freq, cv[i].h, cv[i].l);
            if (cv[i].exp_trigs != 0) run_slew(cv[i].exp_trigs);
        end

        // a second request held during SLEW is taken only after commit
        send_cfg(32'd60, 400, 0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b1; cfg_freq = 32'd33; cfg_h = 32'sd400; cfg_l = 32'sd64;
        run_slew(5);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        m_tf = 33; m_th = 400; m_tl = 64; m_pend = 1'b1;
        @(negedge clk);
        chk("held_acc_busy",  96'(busy),      96'(1));
        chk("held_acc_ready", 96'(cfg_ready), 96'(0));
        chk("held_acc_freq",  96'(freq_cnt),  96'(60));
        run_slew(2);

        // asynchronous reset in the middle of a slew
        do_reset();
        send_cfg(32'd50, 100, -100);
        trigger_once(c);
        trigger_once(c);
        chk("mid_slew_h", 96'(amp_h), 96'(64));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {freq_cnt, amp_h, amp_l}, pack3(100, 0, 0));
        chk("async_rst_ready",   96'(cfg_ready), 96'(1));
        chk("async_rst_busy",    96'(busy),      96'(0));
        chk("async_rst_state",   96'(dbg_state), 96'(ST_IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_idle("after_rst");
        send_cfg(32'd50, -10, 10);
        run_slew(2);

`ifdef MOD_CFG_WATCHDOG_EN
        // stalled generator: no boundary pulses at all
        send_cfg(32'd40, -500, 500);
        wd_n = 0;
        c = 1'b0;
        while (!c && wd_n < 100) begin
            @(posedge clk);
            wd_n++;
            @(negedge clk);
            c = commit;
        end
        chk("wd_cycles",  96'(wd_n), 96'(20));
        chk("wd_outputs", {freq_cnt, amp_h, amp_l}, pack3(40, -500, 500));
        chk("wd_commit",  96'(commit),  96'(1));
        chk("wd_err",     96'(cfg_err), 96'(1));
        m_freq = 40; m_h = -500; m_l = 500; m_pend = 1'b0;
        @(negedge clk);
        chk("wd_pulse_clear", {94'(0), commit, cfg_err}, 96'(0));
        check_idle("wd_after");
`else
        wd_n = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
